// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM encoding and lane width for the execute ALU.
// Imported by alu_exec_unit and conv_mac_lane.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LOAD = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_RSVD = 3'b110;
  localparam logic [2:0] ALU_CONV = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LANE_W = 8;

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: signed int8 x int8 product added to a WIDTH-bit accumulator.
// Ports: a_lane/b_lane int8 operands, acc_in base, acc_out = acc_in + a*b (wraps).
module conv_mac_lane
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [LANE_W-1:0] a_lane,
  input  logic [LANE_W-1:0] b_lane,
  input  logic [WIDTH-1:0]  acc_in,
  output logic [WIDTH-1:0]  acc_out
);

  logic signed [2*LANE_W-1:0] prod;

  assign prod    = $signed(a_lane) * $signed(b_lane);
  // Signed cast sign-extends the product to the accumulator width.
  assign acc_out = acc_in + WIDTH'(prod);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute ALU, 1-cycle scalar ops plus multi-cycle int8 conv MAC.
// Ports: clk, rst (async low), in_valid/in_ready, ALUControl, A, B, acc_clr;
// out_valid pulse with Result, Zero, Negative, Carry, OverFlow.
// Option: define CONV_RELU_EN to clamp negative conv results to zero.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             OverFlow
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    lane_cnt_q, lane_cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             clr_q, clr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             slt;
  logic [WIDTH-1:0] mac_base;
  logic [WIDTH-1:0] mac_out;
  logic [WIDTH-1:0] conv_res;
  logic             last_lane;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // Subtract is A + ~B + 1 so carry means "no borrow".
  assign sub_op = (ALUControl == ALU_SUB);
  assign b_eff  = sub_op ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_eff}
                + {{WIDTH{1'b0}}, sub_op};
  assign slt    = $signed(A) < $signed(B);

  assign last_lane = (lane_cnt_q == CW'(LANES - 1));
  assign mac_base  = (lane_cnt_q == '0 && clr_q)
                   ? '0 : acc_q;

  conv_mac_lane #(.WIDTH(WIDTH)) u_mac (
    .a_lane (a_q[lane_cnt_q*LANE_W +: LANE_W]),
    .b_lane (b_q[lane_cnt_q*LANE_W +: LANE_W]),
    .acc_in (mac_base),
    .acc_out(mac_out)
  );

`ifdef CONV_RELU_EN
  assign conv_res = mac_out[WIDTH-1] ? '0 : mac_out;
`else
  assign conv_res = mac_out;
`endif

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    clr_d       = clr_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && ALUControl == ALU_CONV) begin
          state_d    = ST_MAC;
          lane_cnt_d = '0;
          a_d        = A;
          b_d        = B;
          clr_d      = acc_clr;
        end else if (accept) begin
          out_valid_d = 1'b1;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          unique case (ALUControl)
            ALU_ADD, ALU_SUB: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (A[WIDTH-1] == b_eff[WIDTH-1])
                       & (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_AND:  result_d = A & B;
            ALU_OR:   result_d = A | B;
            ALU_LOAD: result_d = B;
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
            default:  result_d = '0;
          endcase
          zero_d = (result_d == '0);
          neg_d  = result_d[WIDTH-1];
        end
      end
      ST_MAC: begin
        acc_d      = mac_out;
        lane_cnt_d = lane_cnt_q + CW'(1);
        if (last_lane) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = conv_res;
          zero_d      = (conv_res == '0);
          neg_d       = conv_res[WIDTH-1];
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lane_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      clr_q       <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      clr_q       <= clr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign OverFlow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: random + directed stimulus against a behavioural model.
// Honours CONV_RELU_EN the same way the design does.
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam int L = 4;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         acc_clr = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] Result;
  logic         Zero, Negative, Carry, OverFlow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(op), .A(a), .B(b), .acc_clr(acc_clr),
    .out_valid(out_valid), .Result(Result),
    .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .OverFlow(OverFlow)
  );

  typedef struct packed {
    logic         valid;
    logic [W-1:0] res;
    logic         z, n, c, v;
    logic [3:0]   busy;
    logic [W-1:0] acc;
  } model_t;

  model_t m = '0;

  function automatic logic [W-1:0] conv_calc(
    input logic [W-1:0] base, av, bv);
    logic [W-1:0] s;
    int pa, pb;
    s = base;
    for (int i = 0; i < L; i++) begin
      pa = int'($signed(av[8*i +: 8]));
      pb = int'($signed(bv[8*i +: 8]));
      s  = s + W'(pa * pb);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
`ifdef CONV_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic model_t step(
    input model_t cur, input logic iv, input logic [2:0] o,
    input logic [W-1:0] av, bv, input logic clr);
    model_t nx;
    longint unsigned ua, ub;
    longint sa, sb, s;
    logic [W-1:0] r;
    nx = cur;
    nx.valid = 1'b0;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (cur.busy != 0) begin
      nx.busy = cur.busy - 4'd1;
      if (nx.busy == 4'd1) begin
        nx.valid = 1'b1;
        nx.res = relu(cur.acc);
        nx.z = (nx.res == '0);
        nx.n = nx.res[W-1];
        nx.c = 1'b0;
        nx.v = 1'b0;
      end
    end else if (iv && o == 3'b111) begin
      nx.acc  = conv_calc(clr ? '0 : cur.acc, av, bv);
      nx.busy = 4'(L + 1);
    end else if (iv) begin
      nx.valid = 1'b1;
      nx.c = 1'b0;
      nx.v = 1'b0;
      case (o)
        3'b000: begin
          r = av + bv;
          nx.c = (ua + ub) > 64'hFFFF_FFFF;
          s = sa + sb;
          nx.v = (s > MAXS) || (s < MINS);
        end
        3'b001: begin
          r = av - bv;
          nx.c = (av >= bv);
          s = sa - sb;
          nx.v = (s > MAXS) || (s < MINS);
        end
        3'b010:  r = av & bv;
        3'b011:  r = av | bv;
        3'b100:  r = bv;
        3'b101:  r = (sa < sb) ? 1 : 0;
        default: r = '0;
      endcase
      nx.res = r;
      nx.z = (r == '0);
      nx.n = r[W-1];
    end
    return nx;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m = '0;
      else m = step(m, in_valid, op, a, b, acc_clr);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if ({out_valid, in_ready, Result, Zero, Negative, Carry, OverFlow}
          !== {m.valid, (m.busy == 0), m.res, m.z, m.n, m.c, m.v}) begin
        n_bad++;
        $display("FAIL model t=%0t got v%b r%b %h z%b n%b c%b o%b want v%b r%b %h z%b n%b c%b o%b",
          $time, out_valid, in_ready, Result, Zero, Negative, Carry,
          OverFlow, m.valid, (m.busy == 0), m.res, m.z, m.n, m.c, m.v);
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, bv,
                       input logic clr, output int lat, output int nr);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    op = o; a = av; b = bv; acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    nr = in_ready ? 0 : 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) nr++;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  int lat, nr;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", {28'd0, Zero, Negative, Carry, OverFlow}, 32'd0);
    #2 rst = 1'b1;

    do_op(3'b000, 32'd7, 32'd5, 1'b0, lat, nr);
    chk("add_lat", lat, 1);
    chk("add_res", Result, 32'd12);
    chk("add_zc", {Zero, Carry}, 2'b00);

    do_op(3'b001, 32'd5, 32'd5, 1'b0, lat, nr);
    chk("sub_res", Result, 32'd0);
    chk("sub_zcv", {Zero, Carry, OverFlow}, 3'b110);

    do_op(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, lat, nr);
    chk("ovf_res", Result, 32'h8000_0000);
    chk("ovf_nv", {Negative, OverFlow}, 2'b11);

    do_op(3'b111, 32'h0102_0304, 32'h0101_0101, 1'b1, lat, nr);
    chk("conv_lat", lat, L + 1);
    chk("conv_busy", nr, L + 1);
    chk("conv_res", Result, 32'd10);

    do_op(3'b110, 32'd3, 32'd9, 1'b0, lat, nr);
    chk("rsvd", {Result[3:0], Zero}, 5'b00001);
    do_op(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, nr);
    chk("slt", Result, 32'd1);

    do_op(3'b111, 32'hFFFF_FFFF, 32'h0101_0101, 1'b0, lat, nr);
    chk("conv_keep", Result, 32'd6);
    do_op(3'b111, 32'hFFFF_FFFF, 32'h0101_0101, 1'b1, lat, nr);
`ifdef CONV_RELU_EN
    chk("conv_neg", Result, 32'd0);
    chk("conv_neg_z", Zero, 1'b1);
`else
    chk("conv_neg", Result, 32'hFFFF_FFFC);
    chk("conv_neg_n", Negative, 1'b1);
`endif

    @(negedge clk);
    op = 3'b111; a = 32'h0102_0304; b = 32'h0101_0101;
    acc_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    do_op(3'b111, 32'h0102_0304, 32'h0101_0101, 1'b0, lat, nr);
    chk("abort_acc", Result, 32'd10);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) == 0) ? 3'b111
         : 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      acc_clr = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
